mem_port_arbiter: RTL and testbench

//  Shares one single-command memory port between the instruction-fetch requester (I, read-only)
//  and the data requester (D, read/write). Sits between the CPU/cache front end and the memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/rr_grant2.sv | 21 ++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter: default word size, FSM states
// and grant encoding.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/rr_grant2.sv
// Combinational two-way picker between the instruction (I) and data (D) requesters.
// The round-robin pointer is kept by the parent; this block only decides.
module rr_grant2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,     // bit 0 = I, bit 1 = D
  input  gnt_e       last,
  input  logic       prio_d,
  output gnt_e       gnt
);

  always_comb begin
    gnt = GNT_I;
    if (req == 2'b10) begin
      gnt = GNT_D;
    end else if (req == 2'b11) begin
      gnt = (prio_d || (last == GNT_I)) ? GNT_D : GNT_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-command memory port between instruction fetch (read-only)
// and data (read/write) requesters, one access at a time, with a watchdog.
module mem_port_arbiter #(
  parameter int WORD_SIZE  = mem_port_arbiter_pkg::WORD_SIZE,
  parameter int D_PRIORITY = 0,
  parameter int TIMEOUT    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ack,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ack,
  output logic                 err,
  output logic                 m_readM,
  output logic                 m_writeM,
  output logic [WORD_SIZE-1:0] m_address,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  input  logic                 m_ready
);
  import mem_port_arbiter_pkg::*;

  localparam int             WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_ONE  = WDW'(1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT);

  state_e                 state_q, state_d;
  gnt_e                   gnt_q, gnt_d;
  gnt_e                   rr_last_q, rr_last_d;
  gnt_e                   pick;
  logic                   we_q, we_d;
  logic [WORD_SIZE-1:0]   addr_q, addr_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]   i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0]   d_rdata_q, d_rdata_d;
  logic [WDW-1:0]         wdog_q, wdog_d;
  logic                   err_pend_q, err_pend_d;

  rr_grant2 u_rr_grant2 (
    .req    ({d_req, i_req}),
    .last   (rr_last_q),
    .prio_d (D_PRIORITY != 0),
    .gnt    (pick)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= GNT_I;
      rr_last_q  <= GNT_I;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      wdog_q     <= '0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_last_q  <= rr_last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      wdog_q     <= wdog_d;
      err_pend_q <= err_pend_d;
    end
  end

  // The watchdog holds the number of the current ACCESS cycle, starting at 1.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_last_d  = rr_last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    wdog_d     = wdog_q;
    err_pend_d = err_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_d    = ST_ACCESS;
          gnt_d      = pick;
          rr_last_d  = pick;
          wdog_d     = WD_ONE;
          err_pend_d = 1'b0;
          if (pick == GNT_D) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = i_addr;
            wdata_d = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (m_ready) begin
          state_d = ST_RESP;
          if (!we_q) begin
            if (gnt_q == GNT_D) begin
              d_rdata_d = m_rdata;
            end else begin
              i_rdata_d = m_rdata;
            end
          end
        end else if (wdog_q == WD_LAST) begin
          state_d    = ST_RESP;
          err_pend_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_ONE;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        wdog_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    err       = 1'b0;
    m_readM   = 1'b0;
    m_writeM  = 1'b0;
    m_address = '0;
    m_wdata   = '0;
    case (state_q)
      ST_ACCESS: begin
        m_readM   = !we_q;
        m_writeM  = we_q;
        m_address = addr_q;
        m_wdata   = wdata_q;
      end
      ST_RESP: begin
        i_ack = (gnt_q == GNT_I);
        d_ack = (gnt_q == GNT_D);
        err   = err_pend_q;
      end
      default: ;
    endcase
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester tasks push expected responses,
// a negedge monitor checks commands, grant fairness and acks against them.
module tb_mem_port_arbiter;

  localparam int W    = 16;
  localparam int TMO  = 8;
  localparam int DPRI = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n = 1'b0;
  logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [W-1:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [W-1:0] i_rdata, d_rdata, m_address, m_wdata;
  logic         i_ack, d_ack, err, m_readM, m_writeM;
  logic [W-1:0] m_rdata = '0;
  logic         m_ready = 1'b0;

  mem_port_arbiter #(.WORD_SIZE(W), .D_PRIORITY(DPRI), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready)
  );

  // Second instance with D priority, served by a fixed one-cycle memory.
  logic         p_i_req = 1'b0, p_d_req = 1'b0;
  logic [W-1:0] p_i_addr = 16'h0007, p_d_addr = 16'h0042, p_d_wdata = 16'h1234;
  logic [W-1:0] p_i_rdata, p_d_rdata, p_m_address, p_m_wdata;
  logic         p_i_ack, p_d_ack, p_err, p_m_readM, p_m_writeM;
  logic [W-1:0] p_m_rdata = 16'h5A5A;
  logic         p_m_ready = 1'b0;

  mem_port_arbiter #(.WORD_SIZE(W), .D_PRIORITY(1), .TIMEOUT(TMO)) u_dut_p (
    .clk(clk), .reset_n(reset_n),
    .i_req(p_i_req), .i_addr(p_i_addr), .i_rdata(p_i_rdata), .i_ack(p_i_ack),
    .d_req(p_d_req), .d_we(1'b0), .d_addr(p_d_addr), .d_wdata(p_d_wdata),
    .d_rdata(p_d_rdata), .d_ack(p_d_ack), .err(p_err),
    .m_readM(p_m_readM), .m_writeM(p_m_writeM), .m_address(p_m_address),
    .m_wdata(p_m_wdata), .m_rdata(p_m_rdata), .m_ready(p_m_ready)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory models and reference state ----------------
  logic [W-1:0] mem [256];
  logic [W-1:0] ref_mem [256];
  int           mem_lat = 2;
  bit           hang = 1'b0;
  int           mcnt = 0;
  logic [W-1:0] i_last = '0, d_last = '0;

  always @(negedge clk) begin
    if (m_readM || m_writeM) begin
      mcnt++;
      if (!hang && mcnt == mem_lat) begin
        m_ready = 1'b1;
        if (m_writeM) mem[m_address[7:0]] = m_wdata;
        else          m_rdata = mem[m_address[7:0]];
      end else begin
        m_ready = 1'b0;
        m_rdata = W'($urandom);
      end
    end else begin
      mcnt    = 0;
      m_ready = 1'b0;
      m_rdata = W'($urandom);
    end
    p_m_ready = (p_m_readM || p_m_writeM) && !p_m_ready;
  end

  typedef struct {
    logic [W-1:0] rdata;
    logic         err;
    int           cycles;
  } exp_t;

  exp_t exp_i[$];
  exp_t exp_d[$];
  bit   ack_log[$];   // 1 = D acked, 0 = I acked

  // ---------------- monitor ----------------
  bit           snap_i, snap_d, snap_dwe;
  logic [W-1:0] snap_ia, snap_da, snap_dwd, cur_addr;
  bit           prev_cmd, in_acc, cur_gnt, last_srv, exp_gnt, cmd;
  int           cmd_cycles, cyc, last_ack_cyc = -100;
  exp_t         mon_e;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      last_srv     = 1'b0;
      in_acc       = 1'b0;
      prev_cmd     = 1'b0;
      cmd_cycles   = 0;
      last_ack_cyc = -100;
    end else begin
      chk("ack_exclusive", 32'(i_ack & d_ack), 0);
      chk("cmd_exclusive", 32'(m_readM & m_writeM), 0);
      if (err && !(i_ack || d_ack)) chk("err_without_ack", 32'(err), 0);
      cmd = m_readM || m_writeM;
      if (cmd && !prev_cmd) begin
        if (!snap_i && !snap_d) chk("grant_without_req", 32'(cmd), 0);
        exp_gnt = snap_d && (!snap_i || DPRI != 0 || last_srv == 1'b0);
        if (exp_gnt) begin
          chk("cmd_write_flag", 32'(m_writeM), 32'(snap_dwe));
          chk("cmd_addr_d", 32'(m_address), 32'(snap_da));
          if (snap_dwe) chk("cmd_wdata", 32'(m_wdata), 32'(snap_dwd));
          cur_addr = snap_da;
        end else begin
          chk("cmd_read_i", 32'(m_readM), 1);
          chk("cmd_addr_i", 32'(m_address), 32'(snap_ia));
          cur_addr = snap_ia;
        end
        cur_gnt    = exp_gnt;
        last_srv   = exp_gnt;
        in_acc     = 1'b1;
        cmd_cycles = 1;
      end else if (cmd) begin
        cmd_cycles++;
        chk("cmd_addr_hold", 32'(m_address), 32'(cur_addr));
      end
      if (i_ack || d_ack) begin
        if (!in_acc) begin
          chk("unexpected_ack", 32'({i_ack, d_ack}), 0);
        end else begin
          chk("ack_owner", 32'(d_ack), 32'(cur_gnt));
          chk("ack_gap", 32'((cyc - last_ack_cyc) >= 3), 1);
          if (d_ack ? exp_d.size() == 0 : exp_i.size() == 0) begin
            chk("ack_with_empty_queue", 32'({i_ack, d_ack}), 0);
          end else begin
            mon_e = d_ack ? exp_d.pop_front() : exp_i.pop_front();
            if (d_ack) chk("d_rdata", 32'(d_rdata), 32'(mon_e.rdata));
            else       chk("i_rdata", 32'(i_rdata), 32'(mon_e.rdata));
            chk("err", 32'(err), 32'(mon_e.err));
            chk("cmd_cycles", 32'(cmd_cycles), 32'(mon_e.cycles));
          end
          ack_log.push_back(d_ack);
        end
        in_acc       = 1'b0;
        last_ack_cyc = cyc;
      end
      prev_cmd = cmd;
    end
    snap_i   = i_req;
    snap_d   = d_req;
    snap_dwe = d_we;
    snap_ia  = i_addr;
    snap_da  = d_addr;
    snap_dwd = d_wdata;
  end

  // ---------------- requester tasks (called at posedge+1) ----------------
  task automatic i_access(input logic [W-1:0] addr);
    exp_t e;
    int   n = 0;
    e.err    = hang;
    e.cycles = hang ? TMO : mem_lat;
    if (hang) e.rdata = i_last;
    else begin
      e.rdata = ref_mem[addr[7:0]];
      i_last  = e.rdata;
    end
    exp_i.push_back(e);
    i_addr = addr;
    i_req  = 1'b1;
    do begin @(negedge clk); n++; end while (!i_ack && n < 100);
    chk("i_ack_wait", 32'(i_ack), 1);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic d_access(input bit we, input logic [W-1:0] addr, input logic [W-1:0] wdata);
    exp_t e;
    int   n = 0;
    e.err    = hang;
    e.cycles = hang ? TMO : mem_lat;
    if (we) begin
      if (!hang) ref_mem[addr[7:0]] = wdata;
      e.rdata = d_last;
    end else if (hang) begin
      e.rdata = d_last;
    end else begin
      e.rdata = ref_mem[addr[7:0]];
      d_last  = e.rdata;
    end
    exp_d.push_back(e);
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    d_req   = 1'b1;
    do begin @(negedge clk); n++; end while (!d_ack && n < 100);
    chk("d_ack_wait", 32'(d_ack), 1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", 32'({i_ack, d_ack, err, m_readM, m_writeM}), 0);
    chk("rst_cmd", {m_address, m_wdata}, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    i_last  = '0;
    d_last  = '0;
  endtask

  task automatic gap(input int g);
    if (g > 0) begin
      repeat (g) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, ni, nd;
    logic [W-1:0] v;
    for (int a = 0; a < 256; a++) begin
      v          = W'($urandom);
      mem[a]     = v;
      ref_mem[a] = v;
    end
    mem[8'h23] = 16'h6000; ref_mem[8'h23] = 16'h6000;
    mem[8'h01] = 16'h0001; ref_mem[8'h01] = 16'h0001;

    do_reset();

    // single instruction read
    i_access(16'h0023);

    // simultaneous requests after reset: D first, then I
    do_reset();
    ack_log.delete();
    fork
      d_access(1'b0, 16'h0001, 16'h0000);
      i_access(16'h0023);
    join
    chk("t2_ack_count", 32'(ack_log.size()), 2);
    if (ack_log.size() == 2) begin
      chk("t2_first_d", 32'(ack_log[0]), 1);
      chk("t2_second_i", 32'(ack_log[1]), 0);
    end

    // write then read back
    d_access(1'b1, 16'h0010, 16'hBEEF);
    d_access(1'b0, 16'h0010, 16'h0000);

    // both held continuously: strict alternation starting with D
    do_reset();
    ack_log.delete();
    fork
      for (int k = 0; k < 4; k++) d_access(1'b0, W'($urandom_range(0, 255)), 16'h0000);
      for (int k = 0; k < 4; k++) i_access(W'($urandom_range(0, 63)));
    join
    chk("t4_ack_count", 32'(ack_log.size()), 8);
    if (ack_log.size() == 8) begin
      for (int k = 0; k < 8; k++) chk("t4_alternate", 32'(ack_log[k]), 32'(k % 2 == 0));
    end

    // memory never answers: watchdog abort, then normal access
    hang = 1'b1;
    i_access(16'h0005);
    hang = 1'b0;
    i_access(16'h0006);

    // reset in the middle of an access
    i_addr = 16'h0030;
    i_req  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_readM && n < 20);
    chk("t6_access_seen", 32'(m_readM), 1);
    @(posedge clk); #1;
    i_req = 1'b0;
    do_reset();
    repeat (6) @(negedge clk);
    chk("t6_no_ack", 32'({i_ack, d_ack, m_readM}), 0);
    @(posedge clk); #1;

    // D priority instance: D only while both held, I once D drops
    p_i_req = 1'b1;
    p_d_req = 1'b1;
    ni = 0; nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (p_i_ack) ni++;
      if (p_d_ack) begin
        nd++;
        chk("p_d_rdata", 32'(p_d_rdata), 32'h5A5A);
        chk("p_err", 32'(p_err), 0);
      end
      if (p_m_readM) chk("p_cmd_addr", {p_m_address, p_m_wdata}, {16'h0042, 16'h1234});
      if (p_m_writeM) chk("p_no_write", 32'(p_m_writeM), 0);
    end
    chk("p_i_starved", 32'(ni), 0);
    chk("p_d_served", 32'(nd >= 8), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!p_d_ack && n < 10);
    chk("p_d_ack_wait", 32'(p_d_ack), 1);
    @(posedge clk); #1;
    p_d_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!p_i_ack && !p_d_ack && n < 10);
    chk("p_i_after_drop", 32'({p_i_ack, p_d_ack}), 32'b10);
    chk("p_i_rdata", 32'(p_i_rdata), 32'h5A5A);
    @(posedge clk); #1;
    p_i_req = 1'b0;

    // randomized traffic at several memory latencies
    for (int s = 0; s < 4; s++) begin
      mem_lat = $urandom_range(1, 4);
      fork
        for (int k = 0; k < 12; k++) begin
          gap($urandom_range(0, 3));
          i_access(W'($urandom_range(0, 63)));
        end
        for (int k = 0; k < 12; k++) begin
          gap($urandom_range(0, 3));
          if ($urandom_range(0, 1) == 1)
            d_access(1'b1, W'($urandom_range(64, 255)), W'($urandom));
          else
            d_access(1'b0, W'($urandom_range(0, 255)), 16'h0000);
        end
      join
    end

    repeat (5) @(posedge clk);
    chk("exp_i_drained", 32'(exp_i.size()), 0);
    chk("exp_d_drained", 32'(exp_d.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
